sbox_share_arbiter: RTL and testbench
=====================================

Name: sbox_share_arbiter

Overview:
- Shares one pipelined SubBytes S-box lane between two requesters: the round datapath (D) and the key schedule (K).
- Arbitrates byte requests with valid/ready handshakes and drives the S-box lane input.
- Tracks each in-flight byte's owner through a tag pipeline matched to the S-box latency, and returns each result only to its owner.
- Sits between the round controller / key expansion and the sub_byte slice.

Parameters:
- LATENCY, 2, S-box pipeline depth in cycles from sbox_in to sbox_out; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- d_req_valid  in  1  datapath byte request
- d_req_byte  in  8  datapath byte to substitute
- d_req_ready  out  1  datapath request accepted this cycle
- d_rsp_valid  out  1  datapath result valid (single-cycle pulse)
- d_rsp_byte  out  8  datapath substituted byte
- k_req_valid  in  1  key-schedule byte request
- k_req_byte  in  8  key-schedule byte to substitute
- k_req_lock  in  1  keep K's grant after this beat (word bursts)
- k_req_ready  out  1  key-schedule request accepted this cycle
- k_rsp_valid  out  1  key-schedule result valid (single-cycle pulse)
- k_rsp_byte  out  8  key-schedule substituted byte
- sbox_in_valid  out  1  lane input valid
- sbox_in  out  8  lane input byte
- sbox_out  in  8  lane output, valid LATENCY cycles after its input
- busy  out  1  any beat in flight or lock held

Behaviour:
- Beat acceptance: X_req_valid and X_req_ready in the same cycle; at most one beat accepted per cycle.
- Ready is combinational from valids, lock and the priority pointer. Only the winner sees ready=1; the other sees ready=0. Ready never depends on a response.
- Arbitration state: prio (0 = D first, 1 = K first) and lock.
- lock=0, both requesting: the prio side wins.
- lock=0, one requesting: that side wins regardless of prio.
- After any accepted beat with lock=0, prio points to the side that did not win (round-robin).
- Lock entry: a K beat accepted with k_req_lock=1 sets lock=1.
- While lock=1: d_req_ready=0 and k_req_ready=k_req_valid. Idle K cycles keep the lock.
- Lock exit: a K beat accepted with k_req_lock=0 clears lock and sets prio=0.
- A D beat never sets lock; k_req_lock is ignored on non-accepted cycles.
- Lane drive: sbox_in_valid=1 exactly on acceptance cycles; sbox_in = the winner's byte, else 8'h00.
- Tag pipeline: LATENCY stages of {valid, owner}. Stage 0 is loaded on acceptance; stages shift every cycle with no stall.
- Response: when the last stage is valid, pulse X_rsp_valid for its owner with X_rsp_byte=sbox_out. Non-owner rsp_valid=0 and both rsp_byte outputs are 8'h00 when not valid.
- Requesters must sink responses; there is no response backpressure.
- Throughput: one byte per cycle sustained. Request-to-response latency is exactly LATENCY cycles after the acceptance edge.
- Responses return in acceptance order, with one response per accepted beat, never duplicated or lost.
- busy = lock OR any tag stage valid.
- Reset (rst=1 at a clock edge):
  - lock=0, prio=0, all tag stages cleared.
  - While rst=1, both ready outputs, sbox_in_valid, both rsp_valid and busy are 0; sbox_in and both rsp_byte are 8'h00.
  - Beats in flight at reset produce no response, including after rst falls.
- Simultaneous events:
  - A response leaving the last stage and a new acceptance in the same cycle are both handled.
  - A lock exit and a D request in the same cycle: D is not granted that cycle, and wins next cycle if still requesting.

Test Plan:
- LATENCY=2; D sends 8'h00 alone -> d_req_ready=1 that cycle; d_rsp_valid pulses 2 cycles later with d_rsp_byte=8'h63; k_rsp_valid stays 0.
- D and K both valid for 4 cycles with bytes D:00,01,53,FF and K:FF,53,01,00, lock=0 -> grants alternate D,K,D,K,... from reset prio; each side receives correct in-order results (S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16).
- K sends 4 beats with lock=1,1,1,0 while D is valid throughout -> d_req_ready=0 for those 4 beats; D is granted on the cycle after the 4th K beat; busy=1 throughout.
- Back-to-back D beats 10 cycles long -> sbox_in_valid high 10 consecutive cycles; 10 consecutive d_rsp_valid pulses starting LATENCY cycles later.
- Assert rst for 1 cycle with 2 beats in flight -> no rsp_valid pulses afterwards; busy=0; next D request granted first (prio=0).
- Repeat the round-robin and burst scenarios with LATENCY=1 and LATENCY=4 -> same ordering and values, with response shift equal to LATENCY.

Source files
------------

// File: rtl/sbox_share_arbiter_if.sv
`default_nettype none
// sbox_share_arbiter_if : request/response bundle for the datapath (d_*) and key-schedule (k_*)
// requesters of the shared S-box lane. Revision 1.0

interface sbox_share_arbiter_if;
  logic       d_req_valid;
  logic [7:0] d_req_byte;
  logic       d_req_ready;
  logic       d_rsp_valid;
  logic [7:0] d_rsp_byte;
  logic       k_req_valid;
  logic [7:0] k_req_byte;
  logic       k_req_lock;
  logic       k_req_ready;
  logic       k_rsp_valid;
  logic [7:0] k_rsp_byte;

  modport master (
    output d_req_valid, d_req_byte, k_req_valid, k_req_byte, k_req_lock,
    input  d_req_ready, d_rsp_valid, d_rsp_byte, k_req_ready, k_rsp_valid, k_rsp_byte
  );

  modport slave (
    input  d_req_valid, d_req_byte, k_req_valid, k_req_byte, k_req_lock,
    output d_req_ready, d_rsp_valid, d_rsp_byte, k_req_ready, k_rsp_valid, k_rsp_byte
  );
endinterface

`default_nettype wire

// File: rtl/sbox_share_arbiter.sv
`default_nettype none
// sbox_share_arbiter : round-robin / lockable arbiter sharing one pipelined S-box lane,
// with an owner-tag pipeline routing each result back to its requester. Revision 1.0

module sbox_share_arbiter #(
  parameter int LATENCY = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  sbox_share_arbiter_if.slave bus,
  output logic                sbox_in_valid,
  output logic [7:0]          sbox_in,
  input  wire logic [7:0]     sbox_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    ARB_D_FIRST = 2'd0,
    ARB_K_FIRST = 2'd1,
    ARB_K_LOCK  = 2'd2
  } arb_state_t;

  arb_state_t         state;
  logic               d_win;
  logic               k_win;
  logic               accept;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_owner;   // 1 = key schedule
  logic               last_valid;
  logic               last_owner;

  always_comb begin
    d_win = 1'b0;
    k_win = 1'b0;
    if (!rst) begin
      case (state)
        ARB_K_LOCK: k_win = bus.k_req_valid;
        ARB_K_FIRST: begin
          k_win = bus.k_req_valid;
          d_win = bus.d_req_valid && !bus.k_req_valid;
        end
        default: begin
          d_win = bus.d_req_valid;
          k_win = bus.k_req_valid && !bus.d_req_valid;
        end
      endcase
    end
  end

  assign accept          = d_win | k_win;
  assign bus.d_req_ready = d_win;
  assign bus.k_req_ready = k_win;
  assign sbox_in_valid   = accept;
  assign sbox_in         = d_win ? bus.d_req_byte : (k_win ? bus.k_req_byte : 8'h00);

  // Any K beat without lock (including a lock exit) hands priority to D.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_D_FIRST;
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= accept;
      tag_owner[0] <= k_win;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
      if (k_win) begin
        state <= bus.k_req_lock ? ARB_K_LOCK : ARB_D_FIRST;
      end else if (d_win) begin
        state <= ARB_K_FIRST;
      end
    end
  end

  assign last_valid      = tag_valid[LATENCY-1] && !rst;
  assign last_owner      = tag_owner[LATENCY-1];

  assign bus.d_rsp_valid = last_valid && !last_owner;
  assign bus.d_rsp_byte  = (last_valid && !last_owner) ? sbox_out : 8'h00;
  assign bus.k_rsp_valid = last_valid && last_owner;
  assign bus.k_rsp_byte  = (last_valid && last_owner) ? sbox_out : 8'h00;

  assign busy            = !rst && ((state == ARB_K_LOCK) || (|tag_valid));

endmodule

`default_nettype wire

// File: tb/tb_sbox_share_arbiter.sv
`default_nettype none
// tb_sbox_share_arbiter : three arbiters (LATENCY 2, 1, 4) driven by identical requests, each
// fed by its own S-box pipeline and checked every cycle against an in-bench reference.

module tb_sbox_share_arbiter;

  logic       clk;
  logic       rst;
  logic       d_v, k_v, k_l;
  logic [7:0] d_b, k_b;

  logic [2:0] d_rdy, k_rdy, d_rv, k_rv, siv, bsy;
  logic [7:0] d_rb [3];
  logic [7:0] k_rb [3];
  logic [7:0] si   [3];

  int checks;
  int fails;
  int cyc;
  bit done;
  bit fin;

  // Reference state: arbitration rules plus one global list of accepted beats.
  bit         m_lock;
  bit         m_prio;
  int         acc_q [$];
  bit         own_q [$];
  logic [7:0] byt_q [$];
  int         rd [3];

  logic [7:0] glog [$];
  logic [7:0] dlog [$];
  logic [7:0] klog [$];
  int         d_t1, g_rr, d_rr, k_rr, g_lk, g_rs;

  logic [7:0] dl [4];
  logic [7:0] kl [4];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic logic [7:0] qget(input logic [7:0] q [$], input int idx);
    return (idx < q.size()) ? q[idx] : 8'hEE;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    sbox_share_arbiter_if bus ();
    logic [7:0] pipe [LAT];
    logic [7:0] sb_out;

    assign bus.d_req_valid = d_v;
    assign bus.d_req_byte  = d_b;
    assign bus.k_req_valid = k_v;
    assign bus.k_req_byte  = k_b;
    assign bus.k_req_lock  = k_l;

    always @(posedge clk) begin
      pipe[0] <= sbox(si[g]);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sb_out = pipe[LAT-1];

    sbox_share_arbiter #(.LATENCY(LAT)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .sbox_in_valid(siv[g]),
      .sbox_in      (si[g]),
      .sbox_out     (sb_out),
      .busy         (bsy[g])
    );

    assign d_rdy[g] = bus.d_req_ready;
    assign k_rdy[g] = bus.k_req_ready;
    assign d_rv[g]  = bus.d_rsp_valid;
    assign k_rv[g]  = bus.k_rsp_valid;
    assign d_rb[g]  = bus.d_rsp_byte;
    assign k_rb[g]  = bus.k_rsp_byte;
  end

  task automatic chk1(input string nm, input int g, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0b expected=%0b", nm, g, cyc, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input int g, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%02h expected=%02h", nm, g, cyc, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : p_cmp
    bit         ewd, ewk, due, own, infl;
    logic [7:0] exp_si, eb;
    int         lat;
    forever begin
      @(negedge clk);
      ewd = 1'b0;
      ewk = 1'b0;
      if (!rst) begin
        if (m_lock) begin
          ewk = k_v;
        end else if (d_v && k_v) begin
          ewd = !m_prio;
          ewk = m_prio;
        end else begin
          ewd = d_v;
          ewk = k_v;
        end
      end
      exp_si = ewd ? d_b : (ewk ? k_b : 8'h00);

      for (int g = 0; g < 3; g++) begin
        lat  = lat_of(g);
        due  = 1'b0;
        infl = 1'b0;
        own  = 1'b0;
        eb   = 8'h00;
        if (!rst && rd[g] < acc_q.size()) begin
          infl = acc_q[rd[g]] < cyc;
          due  = (acc_q[rd[g]] + lat == cyc);
          own  = own_q[rd[g]];
          eb   = sbox(byt_q[rd[g]]);
        end
        chk1("d_req_ready", g, d_rdy[g], ewd);
        chk1("k_req_ready", g, k_rdy[g], ewk);
        chk1("sbox_in_valid", g, siv[g], ewd | ewk);
        chk8("sbox_in", g, si[g], exp_si);
        chk1("busy", g, bsy[g], !rst && (m_lock || infl));
        chk1("d_rsp_valid", g, d_rv[g], due && !own);
        chk8("d_rsp_byte", g, d_rb[g], (due && !own) ? eb : 8'h00);
        chk1("k_rsp_valid", g, k_rv[g], due && own);
        chk8("k_rsp_byte", g, k_rb[g], (due && own) ? eb : 8'h00);
        if (due) rd[g]++;
        if (rst) rd[g] = acc_q.size();
      end

      if (d_rv[0]) dlog.push_back(d_rb[0]);
      if (k_rv[0]) klog.push_back(k_rb[0]);
      if (d_v && d_rdy[0]) glog.push_back(8'h00);
      else if (k_v && k_rdy[0]) glog.push_back(8'h01);

      if (ewd || ewk) begin
        acc_q.push_back(cyc);
        own_q.push_back(ewk);
        byt_q.push_back(exp_si);
      end

      if (rst) begin
        m_lock = 1'b0;
        m_prio = 1'b0;
      end else if (m_lock) begin
        if (ewk && !k_l) begin
          m_lock = 1'b0;
          m_prio = 1'b0;
        end
      end else if (ewd) begin
        m_prio = 1'b1;
      end else if (ewk) begin
        m_lock = k_l;
        m_prio = 1'b0;
      end

      if (done && !fin) begin
        chk8("pin_sbox_00", 0, sbox(8'h00), 8'h63);
        chk8("pin_sbox_01", 0, sbox(8'h01), 8'h7C);
        chk8("pin_sbox_53", 0, sbox(8'h53), 8'hED);
        chk8("pin_sbox_ff", 0, sbox(8'hFF), 8'h16);
        chk8("single_d_rsp", 0, qget(dlog, d_t1), 8'h63);
        for (int i = 0; i < 8; i++) chk8("rr_grant", 0, qget(glog, g_rr + i), 8'(i % 2));
        chk8("rr_d_rsp0", 0, qget(dlog, d_rr + 0), 8'h63);
        chk8("rr_d_rsp1", 0, qget(dlog, d_rr + 1), 8'h7C);
        chk8("rr_d_rsp2", 0, qget(dlog, d_rr + 2), 8'hED);
        chk8("rr_d_rsp3", 0, qget(dlog, d_rr + 3), 8'h16);
        chk8("rr_k_rsp0", 0, qget(klog, k_rr + 0), 8'h16);
        chk8("rr_k_rsp1", 0, qget(klog, k_rr + 1), 8'hED);
        chk8("rr_k_rsp2", 0, qget(klog, k_rr + 2), 8'h7C);
        chk8("rr_k_rsp3", 0, qget(klog, k_rr + 3), 8'h63);
        for (int i = 0; i < 5; i++) chk8("lock_grant", 0, qget(glog, g_lk + i), (i < 4) ? 8'h01 : 8'h00);
        chk8("post_reset_grant", 0, qget(glog, g_rs), 8'h00);
        fin = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    d_v = 1'b0;
    k_v = 1'b0;
    k_l = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin : p_stim
    int di, ki;
    bit dacc, kacc;
    dl = '{8'h00, 8'h01, 8'h53, 8'hFF};
    kl = '{8'hFF, 8'h53, 8'h01, 8'h00};
    checks = 0;
    fails  = 0;
    m_lock = 1'b0;
    m_prio = 1'b0;
    for (int g = 0; g < 3; g++) rd[g] = 0;
    done = 1'b0;
    fin  = 1'b0;
    rst  = 1'b1;
    d_v  = 1'b0;
    d_b  = 8'h00;
    k_v  = 1'b0;
    k_b  = 8'h00;
    k_l  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Lone datapath byte.
    d_t1 = dlog.size();
    d_v  = 1'b1;
    d_b  = 8'h00;
    @(posedge clk);
    #1 d_v = 1'b0;
    idle(8);

    // Both sides contending, no lock.
    pulse_rst();
    g_rr = glog.size();
    d_rr = dlog.size();
    k_rr = klog.size();
    di = 0;
    ki = 0;
    for (int n = 0; n < 40 && (di < 4 || ki < 4); n++) begin
      d_v = (di < 4);
      d_b = dl[di % 4];
      k_v = (ki < 4);
      k_b = kl[ki % 4];
      @(negedge clk);
      dacc = d_v && d_rdy[0];
      kacc = k_v && k_rdy[0];
      @(posedge clk);
      #1;
      if (dacc) di++;
      if (kacc) ki++;
    end
    d_v = 1'b0;
    k_v = 1'b0;
    idle(8);

    // Locked key-schedule word burst while D waits.
    pulse_rst();
    g_lk = glog.size();
    k_v  = 1'b1;
    k_l  = 1'b1;
    k_b  = 8'($urandom);
    @(posedge clk);
    #1;
    d_v = 1'b1;
    d_b = 8'h53;
    for (int i = 0; i < 3; i++) begin
      k_l = (i != 2);
      k_b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    k_v = 1'b0;
    k_l = 1'b0;
    @(posedge clk);
    #1 d_v = 1'b0;
    idle(8);

    // Ten back-to-back datapath beats.
    for (int i = 0; i < 10; i++) begin
      d_v = 1'b1;
      d_b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    d_v = 1'b0;
    idle(8);

    // Reset with beats in flight, then a contended request.
    d_v = 1'b1;
    d_b = 8'($urandom);
    @(posedge clk);
    #1 d_b = 8'($urandom);
    @(posedge clk);
    #1 d_v = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    g_rs = glog.size();
    d_v  = 1'b1;
    k_v  = 1'b1;
    d_b  = 8'($urandom);
    k_b  = 8'($urandom);
    @(posedge clk);
    #1 d_v = 1'b0;
    k_v = 1'b0;
    idle(8);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      d_v = ($urandom_range(0, 3) != 0);
      k_v = ($urandom_range(0, 2) != 0);
      k_l = ($urandom_range(0, 2) == 0);
      d_b = 8'($urandom);
      k_b = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    d_v = 1'b0;
    k_v = 1'b0;
    k_l = 1'b0;
    idle(8);

    done = 1'b1;
    for (int n = 0; n < 10 && !fin; n++) @(posedge clk);
    if (!fin) begin
      $display("FAIL final_checks not reached");
      $fatal(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
